// File: rtl/spi_pkg.sv
// Shared types for the SPI burst sequencer slice.
// Byte width, sequencer state encoding and a small helper.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        STALL,
        HOLD
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO, registered storage, no fall-through.
// A pop frees a slot for a same-cycle push when full.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer and occupancy values.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
        if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Feeds host bytes to the SPI byte engine one at a time,
// collects MISO bytes and frames each burst with cs_n.
module spi_burst_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_last,
    output logic                  tx_ready,
    output logic                  rx_valid,
    output logic [SPI_BYTE_W-1:0] rx_data,
    input  logic                  rx_ready,
    output logic [SPI_BYTE_W-1:0] eng_data_in,
    output logic                  eng_start,
    input  logic                  eng_done,
    input  logic [SPI_BYTE_W-1:0] eng_data_out,
    output logic                  cs_n,
    output logic                  busy,
    output logic                  rx_overflow
);

    localparam int CNT_W = $clog2(max_int(CS_SETUP, CS_HOLD)) + 1;

    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cs_n_q, cs_n_d;
    logic                  start_q, start_d;
    logic [SPI_BYTE_W-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  ovf_q, ovf_d;

    logic                  tx_full, tx_empty, tx_push, tx_pop;
    logic [SPI_BYTE_W:0]   tx_dout;
    logic                  rx_full, rx_empty, rx_push, rx_pop;
    logic                  done_w;

    assign tx_ready    = !tx_full;
    assign tx_push     = tx_valid && !tx_full;
    assign tx_pop      = (state_q == ISSUE);
    assign rx_valid    = !rx_empty;
    assign rx_pop      = rx_ready && !rx_empty;
    assign done_w      = (state_q == WAIT) && eng_done;
    assign rx_push     = done_w && (!rx_full || rx_pop);
    assign busy        = (state_q != IDLE);
    assign cs_n        = cs_n_q;
    assign eng_start   = start_q;
    assign eng_data_in = data_q;
    assign rx_overflow = ovf_q;

    spi_sync_fifo #(
        .WIDTH (SPI_BYTE_W + 1),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   ({tx_last, tx_data}),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_sync_fifo #(
        .WIDTH (SPI_BYTE_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (eng_data_out),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Sequencer next state, framing counter and engine outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        start_d = 1'b0;
        data_d  = data_q;
        last_d  = last_q;
        ovf_d   = ovf_q | (done_w && rx_full && !rx_pop);
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                if (!tx_empty) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ISSUE: begin
                data_d  = tx_dout[SPI_BYTE_W-1:0];
                last_d  = tx_dout[SPI_BYTE_W];
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    if (last_q) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else if (!tx_empty) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!tx_empty) state_d = ISSUE;
            end
            HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset aborts any open burst at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            start_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            start_q <= start_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer.
// Engine model answers each byte with data ^ 8'h99.
module tb_spi_burst_sequencer;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] eng_data_in;
    logic       eng_start;
    logic       eng_done;
    logic [7:0] eng_data_out;
    logic       cs_n;
    logic       busy;
    logic       rx_overflow;

    int n_err;
    int n_chk;
    int cyc;
    int lat;
    bit eng_en;
    int push_edge;
    bit push_acc;

    bit       pend;
    int       pcnt;
    logic [7:0] pdat;

    bit prev_cs;
    int n_fall;
    int n_rise;
    int fall_cyc;
    int rise_cyc;
    int start_cyc[$];
    logic [7:0] start_dat[$];
    int done_cyc[$];

    spi_burst_sequencer #(
        .DEPTH    (8),
        .CS_SETUP (2),
        .CS_HOLD  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .eng_data_in  (eng_data_in),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .eng_data_out (eng_data_out),
        .cs_n         (cs_n),
        .busy         (busy),
        .rx_overflow  (rx_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Byte engine model: done pulse lat cycles after start.
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (pend) begin
            if (pcnt <= 1) begin
                eng_done     = 1'b1;
                eng_data_out = pdat ^ 8'h99;
                pend         = 1'b0;
            end else begin
                pcnt--;
            end
        end
        if (eng_start && eng_en && !pend) begin
            pend = 1'b1;
            pcnt = lat;
            pdat = eng_data_in;
        end
    end

    // Event recorder, stamps are posedge counts.
    always @(negedge clk) begin
        #2;
        if (prev_cs && !cs_n) begin
            n_fall++;
            fall_cyc = cyc;
        end
        if (!prev_cs && cs_n) begin
            n_rise++;
            rise_cyc = cyc;
        end
        prev_cs = cs_n;
        if (eng_start) begin
            start_cyc.push_back(cyc);
            start_dat.push_back(eng_data_in);
        end
        if (eng_done) done_cyc.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_fall = 0;
        n_rise = 0;
        start_cyc.delete();
        start_dat.delete();
        done_cyc.delete();
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        tick();
        tx_valid  = 1'b1;
        tx_data   = d;
        tx_last   = l;
        push_acc  = tx_ready;
        push_edge = cyc + 1;
    endtask

    task automatic tx_off();
        tick();
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        tick();
        chk({tag, "_v"}, {31'b0, rx_valid}, 1);
        chk(tag, {24'b0, rx_data}, {24'b0, exp});
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!busy && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_start"}, {31'b0, busy}, 1);
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_end"}, {31'b0, busy}, 0);
        tick();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        clr_mon();
    endtask

    initial begin
        n_err    = 0;
        n_chk    = 0;
        cyc      = 0;
        lat      = 10;
        eng_en   = 1'b1;
        pend     = 1'b0;
        pcnt     = 0;
        pdat     = 8'h00;
        prev_cs  = 1'b1;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        rx_ready = 1'b0;
        eng_done = 1'b0;
        eng_data_out = 8'h00;
        clr_mon();

        tick();
        tick();
        chk("rst_cs_n",  {31'b0, cs_n},        1);
        chk("rst_start", {31'b0, eng_start},   0);
        chk("rst_edata", {24'b0, eng_data_in}, 0);
        chk("rst_busy",  {31'b0, busy},        0);
        chk("rst_ovf",   {31'b0, rx_overflow}, 0);
        chk("rst_rxv",   {31'b0, rx_valid},    0);
        chk("rst_txr",   {31'b0, tx_ready},    1);
        rst = 1'b0;
        tick();
        clr_mon();

        // 1) single byte burst
        lat = 10;
        push(8'hA5, 1'b1);
        tx_off();
        wait_idle("t1", 200);
        chk("t1_nstart", start_cyc.size(), 1);
        chk("t1_cs_lat", fall_cyc - push_edge, 1);
        chk("t1_st_lat", start_cyc[0] - fall_cyc, 3);
        chk("t1_edata",  {24'b0, start_dat[0]}, 32'hA5);
        chk("t1_dn_lat", done_cyc[0] - start_cyc[0], 10);
        chk("t1_hold",   rise_cyc - done_cyc[0], 3);
        chk("t1_cs_n",   {31'b0, cs_n}, 1);
        pop("t1_rx", 8'h3C);
        chk("t1_rx_emp", {31'b0, rx_valid}, 0);

        // 2) three byte burst
        clr_mon();
        lat = 4;
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b1);
        tx_off();
        wait_idle("t2", 200);
        chk("t2_nfall",  n_fall, 1);
        chk("t2_nstart", start_cyc.size(), 3);
        chk("t2_d0", {24'b0, start_dat[0]}, 32'h01);
        chk("t2_d1", {24'b0, start_dat[1]}, 32'h02);
        chk("t2_d2", {24'b0, start_dat[2]}, 32'h03);
        chk("t2_b2b1", start_cyc[1] - done_cyc[0], 2);
        chk("t2_b2b2", start_cyc[2] - done_cyc[1], 2);
        chk("t2_hold", rise_cyc - done_cyc[2], 3);
        pop("t2_rx0", 8'h98);
        pop("t2_rx1", 8'h9B);
        pop("t2_rx2", 8'h9A);

        // 3) burst with a gap: STALL keeps cs_n low
        clr_mon();
        lat = 4;
        push(8'h11, 1'b0);
        tx_off();
        for (int i = 0; i < 20; i++) tick();
        chk("t3_busy",  {31'b0, busy}, 1);
        chk("t3_cs_lo", {31'b0, cs_n}, 0);
        chk("t3_n1",    start_cyc.size(), 1);
        chk("t3_done1", done_cyc.size(), 1);
        push(8'h22, 1'b1);
        tx_off();
        wait_idle("t3", 200);
        chk("t3_nfall", n_fall, 1);
        chk("t3_nrise", n_rise, 1);
        chk("t3_n2",    start_cyc.size(), 2);
        chk("t3_d1",    {24'b0, start_dat[1]}, 32'h22);
        pop("t3_rx0", 8'h88);
        pop("t3_rx1", 8'hBB);

        // 4a) RX never popped: ninth byte dropped
        do_reset();
        lat = 2;
        for (int i = 0; i < 9; i++)
            push(8'h40 + 8'(i), (i == 8));
        tx_off();
        wait_idle("t4a", 400);
        chk("t4a_nstart", start_cyc.size(), 9);
        chk("t4a_ovf", {31'b0, rx_overflow}, 1);
        for (int i = 0; i < 8; i++)
            pop("t4a_rx", (8'h40 + 8'(i)) ^ 8'h99);
        chk("t4a_emp", {31'b0, rx_valid}, 0);
        chk("t4a_stky", {31'b0, rx_overflow}, 1);

        // 4b) pop on the cycle the ninth byte arrives
        do_reset();
        chk("t4b_ovf0", {31'b0, rx_overflow}, 0);
        lat = 2;
        for (int i = 0; i < 9; i++)
            push(8'h40 + 8'(i), (i == 8));
        tx_off();
        begin
            int k;
            k = 0;
            while (!(eng_done && done_cyc.size() == 8) && k < 200) begin
                tick();
                k++;
            end
        end
        chk("t4b_9th",  {31'b0, eng_done}, 1);
        chk("t4b_v",    {31'b0, rx_valid}, 1);
        chk("t4b_head", {24'b0, rx_data}, 32'h40 ^ 32'h99);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        wait_idle("t4b", 200);
        chk("t4b_ovf", {31'b0, rx_overflow}, 0);
        for (int i = 1; i < 9; i++)
            pop("t4b_rx", (8'h40 + 8'(i)) ^ 8'h99);
        chk("t4b_emp", {31'b0, rx_valid}, 0);

        // 5) engine stalled: TX fills to 8
        do_reset();
        eng_en = 1'b0;
        push(8'h70, 1'b0);
        tx_off();
        begin
            int k;
            k = 0;
            while (!eng_start && k < 20) begin
                tick();
                k++;
            end
        end
        chk("t5_start", {31'b0, eng_start}, 1);
        for (int i = 0; i < 8; i++) begin
            push(8'h71 + 8'(i), 1'b0);
            chk("t5_acc", {31'b0, push_acc}, 1);
        end
        push(8'h79, 1'b0);
        chk("t5_full", {31'b0, tx_ready}, 0);
        tx_off();
        chk("t5_still", {31'b0, tx_ready}, 0);
        eng_en = 1'b1;

        // 6) reset mid-burst, late done ignored
        do_reset();
        chk("t6_txr0", {31'b0, tx_ready}, 1);
        lat = 6;
        push(8'h61, 1'b0);
        push(8'h62, 1'b0);
        push(8'h63, 1'b0);
        push(8'h64, 1'b1);
        tx_off();
        begin
            int k;
            k = 0;
            while (start_cyc.size() < 2 && k < 100) begin
                tick();
                k++;
            end
        end
        chk("t6_n2", start_cyc.size(), 2);
        tick();
        chk("t6_rxv", {31'b0, rx_valid}, 1);
        chk("t6_pend", {31'b0, pend}, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_cs_n", {31'b0, cs_n}, 1);
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_rxe",  {31'b0, rx_valid}, 0);
        chk("t6_txr",  {31'b0, tx_ready}, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_late",  done_cyc.size(), 2);
        chk("t6_busy2", {31'b0, busy}, 0);
        chk("t6_rxe2",  {31'b0, rx_valid}, 0);
        chk("t6_cs2",   {31'b0, cs_n}, 1);
        chk("t6_nst",   start_cyc.size(), 2);
        clr_mon();
        push(8'h5A, 1'b1);
        tx_off();
        wait_idle("t6", 200);
        chk("t6_new",   {24'b0, start_dat[0]}, 32'h5A);
        chk("t6_nfall", n_fall, 1);
        pop("t6_rx", 8'hC3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
